sync_payload_capture: RTL and testbench
=======================================

// Module: sync_payload_capture
// PURPOSE
// - Downstream stage of the 10000001 sync-word detector; consumes its serial input J and its detect pulse Y.
// - After each sync detect, deserialises the next PAYLOAD_W bits of J (MSB first) into a parallel word.
// - Presents the word on a valid/ready handshake to the byte consumer; counts frames and flags overruns.
// PARAMETERS
// - PAYLOAD_W  default 8  payload bits captured per frame (2..32)
// - CNT_W      default 8  width of the frame counter
// PORTS
// - clk        in   1          system clock, rising edge
// - rst        in   1          asynchronous reset, active-high
// - J          in   1          serial bit stream, same stream fed to the detector
// - Y          in   1          detector output, 1-cycle pulse on sync-word match
// - data_out   out  PAYLOAD_W  captured payload, MSB = first bit after sync
// - valid      out  1          data_out holds an unconsumed frame
// - ready      in   1          consumer accepts data_out when valid && ready at a clock edge
// - busy       out  1          1 while in CAPTURE
// - overrun    out  1          sticky: a sync was dropped because a frame was still pending
// - frame_cnt  out  CNT_W      frames delivered to valid, wraps modulo 2^CNT_W
// - parity_err out  1          only with CAPTURE_PARITY_EN (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, any time, incl. mid-capture): state=IDLE, data_out=0, valid=0, busy=0, overrun=0, frame_cnt=0, bit counter=0, parity_err=0; partial frame discarded.
// - Timing: Y high at edge k -> payload bits are J sampled at edges k+1 .. k+PAYLOAD_W.
// - FSM states: IDLE, CAPTURE, HOLD.
// - IDLE: Y=1 -> CAPTURE, bit counter cleared; otherwise stay.
// - CAPTURE: each edge shift J into LSB of shift register, counter++; Y ignored (payload bits may re-match the sync word).
// - Last bit at edge k+PAYLOAD_W: data_out loads the full word, valid=1, frame_cnt++, next state HOLD; busy=0 from that edge.
// - HOLD: data_out/valid stable until the valid && ready edge; then valid=0 -> IDLE.
// - Same edge: valid && ready with Y=1 in HOLD -> handshake completes AND capture starts (-> CAPTURE); no overrun.
// - HOLD with Y=1, ready=0: overrun set (sticky until reset), sync dropped, stay HOLD.
// - data_out is never altered while valid=1; shift register is internal and separate from data_out.
// - Latency: valid rises PAYLOAD_W cycles after the Y edge; best-case back-to-back frames are PAYLOAD_W+1 cycles apart (sync then payload).
// - frame_cnt wraps 2^CNT_W-1 -> 0 without flagging.
// - ready while valid=0 has no effect.
// CONFIGURATION
// - Macro CAPTURE_PARITY_EN:
// - Defined: one extra bit follows the payload (edge k+PAYLOAD_W+1), even parity over payload+parity bit;
//   valid rises at that edge; parity_err = 1 when parity fails, updated with data_out, held while valid.
// - Not defined: no parity bit, valid at edge k+PAYLOAD_W, parity_err port absent.
// TESTING
// - Reset mid-CAPTURE after 3 payload bits -> all outputs 0, next Y starts a fresh capture with no stale bits.
// - Y pulse then J=1,0,1,0,0,1,0,1, ready=1 -> data_out=8'hA5, valid high exactly 1 cycle, frame_cnt=1.
// - Payload 8'h81 (matches sync) -> captured as 8'h81, no re-trigger inside frame, busy=1 for all 8 bits.
// - ready=0, frame 8'h3C then second Y -> data_out stays 8'h3C, overrun=1, frame_cnt=1; raise ready -> valid=0.
// - Y on the same edge as valid&&ready -> next frame 8'hC3 captured, overrun=0, frame_cnt=2.
// - CAPTURE_PARITY_EN: payload 8'h01 + parity 0 -> parity_err=1; payload 8'h01 + parity 1 -> parity_err=0.

Source files
------------

// File: rtl/sync_payload_capture_if.sv
// ---------------------------------------------------------------------------
// sync_payload_capture_if
// Groups the serial input, detector pulse and consumer handshake of
// sync_payload_capture into one bundle.
//   J          serial bit stream (same stream the sync detector sees)
//   Y          one-cycle sync-detect pulse
//   data_out   captured payload word, MSB = first bit after the sync word
//   valid      data_out holds an unconsumed frame
//   ready      consumer accepts data_out when valid && ready at a clock edge
//   busy       capture of a payload is in progress
//   overrun    sticky: a sync was dropped while a frame was still pending
//   frame_cnt  frames delivered, wraps modulo 2^CNT_W
//   parity_err only when CAPTURE_PARITY_EN is defined
// Modports: master = stimulus/consumer side, slave = capture block.
// ---------------------------------------------------------------------------
interface sync_payload_capture_if #(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 8
);
    logic                 J;
    logic                 Y;
    logic                 ready;
    logic [PAYLOAD_W-1:0] data_out;
    logic                 valid;
    logic                 busy;
    logic                 overrun;
    logic [CNT_W-1:0]     frame_cnt;
`ifdef CAPTURE_PARITY_EN
    logic                 parity_err;

    modport master (output J, Y, ready,
                    input  data_out, valid, busy, overrun, frame_cnt, parity_err);
    modport slave  (input  J, Y, ready,
                    output data_out, valid, busy, overrun, frame_cnt, parity_err);
`else
    modport master (output J, Y, ready,
                    input  data_out, valid, busy, overrun, frame_cnt);
    modport slave  (input  J, Y, ready,
                    output data_out, valid, busy, overrun, frame_cnt);
`endif
endinterface

// File: rtl/sync_payload_capture.sv
// ---------------------------------------------------------------------------
// sync_payload_capture
// Downstream stage of the 10000001 sync-word detector. After each detect
// pulse Y it deserialises the next PAYLOAD_W bits of J (MSB first), then
// offers the word on a valid/ready handshake, counts delivered frames and
// flags syncs dropped while a frame is still pending.
// Ports:
//   clk  rising-edge system clock
//   rst  asynchronous reset, active-high
//   bus  sync_payload_capture_if.slave (J, Y, ready in; data_out, valid,
//        busy, overrun, frame_cnt [, parity_err] out)
// Optional feature macro: CAPTURE_PARITY_EN -- one even-parity bit follows
// the payload; valid rises on that bit and parity_err reports the check.
// ---------------------------------------------------------------------------
module sync_payload_capture #(
    parameter int PAYLOAD_W = 8,
    parameter int CNT_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    sync_payload_capture_if.slave  bus
);

    // Counter must reach PAYLOAD_W when the parity bit is appended.
    localparam int CW = $clog2(PAYLOAD_W + 2);
`ifdef CAPTURE_PARITY_EN
    localparam logic [CW-1:0] LAST_BIT = CW'(PAYLOAD_W);
`else
    localparam logic [CW-1:0] LAST_BIT = CW'(PAYLOAD_W - 1);
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        bit_cnt_r;
    logic [PAYLOAD_W-1:0] shift_r;
    logic [PAYLOAD_W-1:0] data_r;
    logic                 valid_r;
    logic                 busy_r;
    logic                 overrun_r;
    logic [CNT_W-1:0]     frame_cnt_r;

`ifdef CAPTURE_PARITY_EN
    logic                 parity_err_r;

    // Even parity over payload plus parity bit: any odd number of ones fails.
    function automatic logic parity_fail(input logic [PAYLOAD_W-1:0] d,
                                         input logic                 p);
        return ^{d, p};
    endfunction
`endif

    // Capture FSM: sync wait, serial shift-in, and holding the word until it is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            bit_cnt_r    <= {CW{1'b0}};
            shift_r      <= {PAYLOAD_W{1'b0}};
            data_r       <= {PAYLOAD_W{1'b0}};
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
            frame_cnt_r  <= {CNT_W{1'b0}};
`ifdef CAPTURE_PARITY_EN
            parity_err_r <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.Y) begin
                        state_r   <= CAPTURE;
                        bit_cnt_r <= {CW{1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                    end
                end
                // Y is deliberately ignored here: payload bits may re-match the sync word.
                CAPTURE: begin
                    if (bit_cnt_r == LAST_BIT) begin
`ifdef CAPTURE_PARITY_EN
                        // shift_r already holds the whole payload; J is the parity bit.
                        data_r       <= shift_r;
                        parity_err_r <= parity_fail(shift_r, bus.J);
`else
                        data_r       <= {shift_r[PAYLOAD_W-2:0], bus.J};
`endif
                        valid_r     <= 1'b1;
                        busy_r      <= 1'b0;
                        frame_cnt_r <= frame_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        bit_cnt_r   <= {CW{1'b0}};
                        state_r     <= HOLD;
                    end else begin
                        shift_r   <= {shift_r[PAYLOAD_W-2:0], bus.J};
                        bit_cnt_r <= bit_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                // valid is always 1 in HOLD, so ready alone completes the handshake.
                HOLD: begin
                    if (bus.ready) begin
                        valid_r <= 1'b0;
                        if (bus.Y) begin
                            state_r   <= CAPTURE;
                            bit_cnt_r <= {CW{1'b0}};
                            busy_r    <= 1'b1;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end else if (bus.Y) begin
                        overrun_r <= 1'b1;
                    end else begin
                        state_r   <= HOLD;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bit_cnt_r <= {CW{1'b0}};
                    valid_r   <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out  = data_r;
    assign bus.valid     = valid_r;
    assign bus.busy      = busy_r;
    assign bus.overrun   = overrun_r;
    assign bus.frame_cnt = frame_cnt_r;
`ifdef CAPTURE_PARITY_EN
    assign bus.parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_sync_payload_capture.sv
// ---------------------------------------------------------------------------
// tb_sync_payload_capture
// Directed bench for sync_payload_capture (PAYLOAD_W=8, CNT_W=8). Inputs are
// changed on the falling edge and outputs are observed on the next falling
// edge, i.e. after exactly one rising edge has consumed the inputs.
// Works with or without CAPTURE_PARITY_EN defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_payload_capture;

    localparam int PW = 8;
    localparam int CW = 8;

    logic clk;
    logic rst;
    int   checks_r;
    int   failures_r;

    sync_payload_capture_if #(.PAYLOAD_W(PW), .CNT_W(CW)) bus ();

    sync_payload_capture #(.PAYLOAD_W(PW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one set of inputs for exactly one rising edge.
    task automatic cyc(input logic j, input logic y, input logic r);
        bus.J     = j;
        bus.Y     = y;
        bus.ready = r;
        @(negedge clk);
    endtask

    // Shift in a payload word (MSB first) plus, when enabled, its parity bit.
    // ymask puts Y pulses on individual payload bits; the block must ignore them.
    task automatic send_bits(input string tag, input logic [PW-1:0] w, input logic par,
                             input logic [PW-1:0] ymask, input logic r, input bit chk);
        for (int i = PW - 1; i >= 0; i--) begin
            cyc(w[i], ymask[i], r);
`ifdef CAPTURE_PARITY_EN
            if (chk) begin
                check({tag, "_busy_mid"},  {31'd0, bus.busy},  32'd1);
                check({tag, "_valid_mid"}, {31'd0, bus.valid}, 32'd0);
            end
        end
        cyc(par, 1'b0, r);
`else
            if (chk && i > 0) begin
                check({tag, "_busy_mid"},  {31'd0, bus.busy},  32'd1);
                check({tag, "_valid_mid"}, {31'd0, bus.valid}, 32'd0);
            end
        end
`endif
        if (chk) begin
            check({tag, "_valid"}, {31'd0, bus.valid}, 32'd1);
            check({tag, "_data"},  {24'd0, bus.data_out}, {24'd0, w});
            check({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},    {24'd0, bus.data_out}, 32'd0);
        check({tag, "_valid"},   {31'd0, bus.valid},    32'd0);
        check({tag, "_busy"},    {31'd0, bus.busy},     32'd0);
        check({tag, "_overrun"}, {31'd0, bus.overrun},  32'd0);
        check({tag, "_cnt"},     {24'd0, bus.frame_cnt}, 32'd0);
`ifdef CAPTURE_PARITY_EN
        check({tag, "_perr"},    {31'd0, bus.parity_err}, 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        checks_r   = 0;
        failures_r = 0;
        bus.J      = 1'b0;
        bus.Y      = 1'b0;
        bus.ready  = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Reset in the middle of a capture, after three payload bits.
        cyc(1'b0, 1'b1, 1'b0);
        check("midrst_busy_pre", {31'd0, bus.busy}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Fresh frame 0xA5 with ready held high: valid lasts exactly one cycle.
        cyc(1'b0, 1'b1, 1'b1);
        send_bits("a5", 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1);
        check("a5_cnt", {24'd0, bus.frame_cnt}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        check("a5_valid_drop", {31'd0, bus.valid}, 32'd0);
        check("a5_data_keep",  {24'd0, bus.data_out}, 32'h0000_00A5);
        cyc(1'b0, 1'b0, 1'b1);
        check("a5_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Payload equal to the sync word, with Y pulses inside the frame.
        cyc(1'b0, 1'b1, 1'b0);
        send_bits("p81", 8'h81, 1'b0, 8'h11, 1'b0, 1'b1);
        check("p81_cnt", {24'd0, bus.frame_cnt}, 32'd2);
        check("p81_ovr", {31'd0, bus.overrun},   32'd0);
        cyc(1'b0, 1'b0, 1'b1);
        check("p81_valid_drop", {31'd0, bus.valid}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0);
        check("p81_no_retrig", {31'd0, bus.busy}, 32'd0);

        // Pending 0x3C, then a second sync without ready: dropped, overrun.
        cyc(1'b0, 1'b1, 1'b0);
        send_bits("p3c", 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        check("ovr_flag",  {31'd0, bus.overrun},    32'd1);
        check("ovr_data",  {24'd0, bus.data_out},   32'h0000_003C);
        check("ovr_valid", {31'd0, bus.valid},      32'd1);
        check("ovr_busy",  {31'd0, bus.busy},       32'd0);
        check("ovr_cnt",   {24'd0, bus.frame_cnt},  32'd3);
        cyc(1'b1, 1'b0, 1'b0);
        check("ovr_hold_data", {24'd0, bus.data_out}, 32'h0000_003C);
        cyc(1'b0, 1'b0, 1'b1);
        check("ovr_valid_drop", {31'd0, bus.valid},  32'd0);
        check("ovr_sticky",     {31'd0, bus.overrun}, 32'd1);

        // Handshake and sync on the same edge: next frame starts, no overrun.
        do_reset();
        cyc(1'b0, 1'b1, 1'b0);
        send_bits("p5a", 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        check("same_valid", {31'd0, bus.valid},   32'd0);
        check("same_busy",  {31'd0, bus.busy},    32'd1);
        check("same_ovr",   {31'd0, bus.overrun}, 32'd0);
        send_bits("c3", 8'hC3, 1'b0, 8'h00, 1'b0, 1'b1);
        check("c3_cnt", {24'd0, bus.frame_cnt}, 32'd2);
        check("c3_ovr", {31'd0, bus.overrun},   32'd0);
        cyc(1'b0, 1'b0, 1'b1);

        // Frame counter wraps 255 -> 0 silently.
        for (int n = 0; n < 253; n++) begin
            cyc(1'b0, 1'b1, 1'b0);
            send_bits("wrap", 8'h96, 1'b0, 8'h00, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b1);
        end
        check("wrap_255", {24'd0, bus.frame_cnt}, 32'd255);
        cyc(1'b0, 1'b1, 1'b0);
        send_bits("wrap0", 8'h96, 1'b0, 8'h00, 1'b0, 1'b1);
        check("wrap_0",   {24'd0, bus.frame_cnt}, 32'd0);
        check("wrap_ovr", {31'd0, bus.overrun},   32'd0);
        cyc(1'b0, 1'b0, 1'b1);

`ifdef CAPTURE_PARITY_EN
        // 0x01 has one set bit: parity bit 0 fails, parity bit 1 passes.
        cyc(1'b0, 1'b1, 1'b0);
        send_bits("par0", 8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
        check("par0_err", {31'd0, bus.parity_err}, 32'd1);
        cyc(1'b0, 1'b0, 1'b0);
        check("par0_err_hold", {31'd0, bus.parity_err}, 32'd1);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        send_bits("par1", 8'h01, 1'b1, 8'h00, 1'b0, 1'b1);
        check("par1_err", {31'd0, bus.parity_err}, 32'd0);
        cyc(1'b0, 1'b0, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
